// File: rtl/arinc_tx_param.sv
// Parametrised ARINC-429-style bipolar RZ transmitter with valid/ready intake,
// optional odd parity and a clock-enable half-bit timer.
module arinc_tx_param #(
    parameter int WIDTH     = 32,
    parameter int GAP_BITS  = 4,
    parameter int HALF_HI   = 250,
    parameter int HALF_LO   = 2000,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             rate_sel,
    output logic             TxA,
    output logic             TxB,
    output logic             busy,
    output logic             done
);

    localparam int HALF_MAX = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;
    localparam int CW       = $clog2(HALF_MAX + 1);
    localparam int BW       = 5;

    typedef enum logic [1:0] {IDLE, BIT_HI, BIT_NULL, GAP} state_t;

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic [WIDTH-1:0] r_sr, w_sr_next;
    logic             r_rate, w_rate_next;
    logic             r_txa, w_txa_next;
    logic             r_txb, w_txb_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             r_tx_ready, w_ready_next;

    logic [WIDTH-1:0] w_load;
    logic [CW-1:0]    w_half_len;
    logic             w_tick;

    generate
        if (PARITY_EN != 0) begin : g_parity
            // The top input bit is replaced, so it is deliberately left unread.
            logic w_unused_msb;
            assign w_unused_msb = tx_data[WIDTH-1];
            assign w_load = {~^tx_data[WIDTH-2:0], tx_data[WIDTH-2:0]};
        end else begin : g_verbatim
            assign w_load = tx_data;
        end
    endgenerate

    assign w_half_len = r_rate ? CW'(HALF_HI) : CW'(HALF_LO);
    assign w_tick     = (r_cnt == w_half_len - CW'(1));

    assign TxA      = r_txa;
    assign TxB      = r_txb;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tx_ready = r_tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_sr       <= '0;
            r_rate     <= 1'b0;
            r_txa      <= 1'b0;
            r_txb      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_sr       <= w_sr_next;
            r_rate     <= w_rate_next;
            r_txa      <= w_txa_next;
            r_txb      <= w_txb_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_tx_ready <= w_ready_next;
        end
    end

    // Line outputs are computed from the next state so they are registered
    // and line up exactly with the slot boundaries.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_tick ? '0 : r_cnt + CW'(1);
        w_bit_cnt_next = r_bit_cnt;
        w_sr_next      = r_sr;
        w_rate_next    = r_rate;
        w_txa_next     = 1'b0;
        w_txb_next     = 1'b0;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_ready_next   = r_tx_ready;

        case (r_state)
            IDLE: begin
                w_cnt_next   = '0;
                w_ready_next = 1'b1;
                if (tx_valid && r_tx_ready) begin
                    w_sr_next      = w_load;
                    w_rate_next    = rate_sel;
                    w_bit_cnt_next = '0;
                    w_busy_next    = 1'b1;
                    w_ready_next   = 1'b0;
                    w_state_next   = BIT_HI;
                    w_txa_next     = w_load[0];
                    w_txb_next     = ~w_load[0];
                end
            end
            BIT_HI: begin
                if (w_tick) begin
                    w_state_next = BIT_NULL;
                end else begin
                    w_txa_next = r_sr[0];
                    w_txb_next = ~r_sr[0];
                end
            end
            BIT_NULL: begin
                if (w_tick) begin
                    w_sr_next = r_sr >> 1;
                    if (r_bit_cnt == BW'(WIDTH - 1)) begin
                        w_state_next   = GAP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BW'(1);
                        w_state_next   = BIT_HI;
                        w_txa_next     = w_sr_next[0];
                        w_txb_next     = ~w_sr_next[0];
                    end
                end
            end
            GAP: begin
                // The bit counter is reused here to count null slots.
                if (w_tick) begin
                    if (r_bit_cnt == BW'(2 * GAP_BITS - 1)) begin
                        w_state_next   = IDLE;
                        w_bit_cnt_next = '0;
                        w_busy_next    = 1'b0;
                        w_ready_next   = 1'b1;
                        w_done_next    = 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arinc_tx_param.sv
// Bench for arinc_tx_param: decodes the line back into words and checks them
// against a scoreboard of expected words and durations.
module tb_arinc_tx_param;

    localparam int W     = 32;
    localparam int GAPB  = 4;
    localparam int H_HI  = 4;
    localparam int H_LO  = 16;
    localparam int NVEC  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          rate_sel = 1'b0;
    logic          tx_ready, TxA, TxB, busy, done;
    logic          u1_ready, u1_A, u1_B, u1_busy, u1_done;

    always #5 clk = ~clk;

    arinc_tx_param #(.WIDTH(W), .GAP_BITS(GAPB), .HALF_HI(H_HI), .HALF_LO(H_LO), .PARITY_EN(1)) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rate_sel(rate_sel), .TxA(TxA), .TxB(TxB), .busy(busy), .done(done)
    );

    arinc_tx_param #(.WIDTH(W), .GAP_BITS(GAPB), .HALF_HI(H_HI), .HALF_LO(H_LO), .PARITY_EN(0)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(u1_ready),
        .rate_sel(rate_sel), .TxA(u1_A), .TxB(u1_B), .busy(u1_busy), .done(u1_done)
    );

    typedef struct {
        logic [31:0] data;
        logic        rate;
        logic [31:0] exp_word;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];

    int checks = 0;
    int failures = 0;

    // Line monitor state for u0.
    int          cyc = 0;
    logic [31:0] acc_word = '0;
    int          pcnt = 0, bad_runs = 0, run = 0, first_off = -1, zrun = 0, lead_zero = 0;
    logic        prev_on = 1'b0;
    int          acc_idx = 0, cur_half = 0, acc_cnt = 0, done_cnt = 0, overlap = 0, ready_hi = 0;
    logic [31:0] last_word = '0;
    int          last_pcnt = 0, last_dur = 0, last_bad = 0, last_first_off = 0, last_lead_zero = 0;
    int          last_done_cyc = 0, last_acc_idx = 0;

    // Line monitor state for u1.
    logic [31:0] u1_acc = '0, u1_last_word = '0;
    int          u1_pc = 0, u1_last_pc = 0;
    logic        u1_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            acc_word = '0; pcnt = 0; bad_runs = 0; run = 0; first_off = -1;
            prev_on = 1'b0; zrun = 0; lead_zero = 0;
        end else begin
            if (TxA && TxB) overlap++;
            if (tx_ready) ready_hi++;
            if (TxA || TxB) begin
                if (!prev_on) begin
                    if (pcnt == 0) begin
                        first_off = cyc - acc_idx;
                        lead_zero = zrun;
                    end
                    acc_word = {TxA, acc_word[31:1]};
                    pcnt++;
                    zrun = 0;
                end
                run++;
            end else begin
                if (prev_on) begin
                    if (run != cur_half) bad_runs++;
                    run = 0;
                end
                zrun++;
            end
            prev_on = TxA || TxB;
            if (done) begin
                last_word      = acc_word;
                last_pcnt      = pcnt;
                last_dur       = cyc - acc_idx;
                last_bad       = bad_runs;
                last_first_off = first_off;
                last_lead_zero = lead_zero;
                last_done_cyc  = cyc;
                done_cnt++;
                acc_word = '0; pcnt = 0; bad_runs = 0; first_off = -1;
            end
            if (tx_valid && tx_ready) begin
                acc_idx      = cyc + 1;
                last_acc_idx = acc_idx;
                cur_half     = rate_sel ? H_HI : H_LO;
                acc_cnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            u1_acc = '0; u1_pc = 0; u1_prev = 1'b0;
        end else begin
            if ((u1_A || u1_B) && !u1_prev) begin
                u1_acc = {u1_A, u1_acc[31:1]};
                u1_pc++;
            end
            u1_prev = u1_A || u1_B;
            if (u1_done) begin
                u1_last_word = u1_acc;
                u1_last_pc   = u1_pc;
                u1_acc = '0; u1_pc = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic r, input logic [31:0] ew,
                        input int ec, input bit push, input bit hold);
        exp_t e;
        int   n;
        if (push) begin
            e.word = ew;
            e.cyc  = ec;
            sb.push_back(e);
        end
        tx_data  = d;
        rate_sel = r;
        tx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("accept", {63'd0, tx_ready}, 64'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            tx_valid = 1'b0;
            rate_sel = ~r;
            tx_data  = $urandom;
        end
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (done_cnt == start && n < 3000);
        chk("done_seen", {63'd0, done_cnt != start}, 64'd1);
    endtask

    task automatic check_word();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            $display("word: sent=%h expected=%h pulses=%0d cycles=%0d", last_word, e.word, last_pcnt, last_dur);
            chk("word_bits", last_word, e.word);
            chk("pulse_count", last_pcnt, W);
            chk("word_cycles", last_dur, e.cyc);
            chk("slot_len_errors", last_bad, 0);
            chk("first_bit_latency", last_first_off, 0);
        end
    endtask

    initial begin
        int n;
        int a0, r0, d0;

        vecs[0] = '{32'h0000_0001, 1'b1, 32'h0000_0001, 288};
        vecs[1] = '{32'h0000_0000, 1'b1, 32'h8000_0000, 288};
        vecs[2] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 1152};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 288};
        vecs[4] = '{32'h1234_5678, 1'b1, 32'h1234_5678, 288};
        vecs[5] = '{32'hA5A5_A5A5, 1'b1, 32'h25A5_A5A5, 288};
        vecs[6] = '{32'h0000_0003, 1'b0, 32'h8000_0003, 1152};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_TxA", {63'd0, TxA}, 64'd0);
        chk("rst_TxB", {63'd0, TxB}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ready", {63'd0, tx_ready}, 64'd0);
        chk("rst_u1_ready_busy", {62'd0, u1_ready, u1_busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_rst", {63'd0, tx_ready}, 64'd1);

        // Table-driven words; inputs are scrambled while each word is in flight
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].data, vecs[i].rate, vecs[i].exp_word, vecs[i].exp_cyc, 1'b1, 1'b0);
            wait_done();
            check_word();
            chk("noparity_word", u1_last_word, vecs[i].data);
            chk("noparity_pulses", u1_last_pc, W);
        end

        // Back-to-back with tx_valid held
        a0 = acc_cnt;
        send(32'hDEAD_BEEF, 1'b1, 32'h5EAD_BEEF, 288, 1'b1, 1'b1);
        r0 = ready_hi;
        begin
            exp_t e;
            e.word = 32'h0F0F_0001;
            e.cyc  = 288;
            sb.push_back(e);
        end
        tx_data = 32'h0F0F_0001;
        wait_done();
        check_word();
        n = 0;
        while (acc_cnt == a0 + 1 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("b2b_accepted", acc_cnt, a0 + 2);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = $urandom;
        chk("b2b_accept_after_done", last_acc_idx - last_done_cyc, 1);
        chk("ready_high_one_cycle", ready_hi - r0, 1);
        wait_done();
        check_word();
        chk("interword_null", last_lead_zero, H_HI + 2 * GAPB * H_HI + 1);

        // Reset during bit 10
        send(32'h5555_5555, 1'b1, 32'h0, 0, 1'b0, 1'b0);
        n = 0;
        while (pcnt < 11 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached_bit10", {63'd0, pcnt >= 11}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_TxA", {63'd0, TxA}, 64'd0);
        chk("abort_TxB", {63'd0, TxB}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_ready", {63'd0, tx_ready}, 64'd0);
        d0 = done_cnt;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_ready_back", {63'd0, tx_ready}, 64'd1);
        repeat (400) @(negedge clk);
        #1;
        chk("no_done_after_abort", done_cnt, d0);
        send(32'h0000_0100, 1'b1, 32'h0000_0100, 288, 1'b1, 1'b0);
        wait_done();
        check_word();

        chk("never_both_lines", overlap, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
